// File: rtl/fc_vec_loader.sv
// Stream-to-parallel activation loader: assembles IN beats of WIDTH bits into a
// held vector for an FC neuron bank, padding short frames and draining long ones.

module fc_vec_entry #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] data_q;
    logic             mask_q;

    always_ff @(posedge clk) begin
        if (rst || clr)
            mask_q <= 1'b0;
        else if (we)
            mask_q <= 1'b1;
        if (we)
            data_q <= d;
    end

    // Mask gating keeps unwritten (or stale) entries at zero on the bus.
    assign q = mask_q ? data_q : '0;
endmodule

module fc_vec_loader #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] x [0:IN-1],
    output logic             x_valid,
    input  logic             x_ready,
    output logic             err_len
);
    localparam int             CW       = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(IN - 1);

    typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           xv_q, err_q, err_d;
    logic           accept, wr, clr;
    logic [IN-1:0]  we_lane;

    assign s_ready = ~rst & (state_q != HOLD);
    assign accept  = s_valid & s_ready;
    assign x_valid = xv_q;
    assign err_len = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        wr      = 1'b0;
        clr     = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    wr = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        // Full buffer: either a clean end or the start of an overlong frame.
                        state_d = s_last ? HOLD : DRAIN;
                        err_d   = ~s_last;
                    end else if (s_last) begin
                        state_d = HOLD;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_last)
                    state_d = HOLD;
            end
            HOLD: begin
                if (x_ready) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            xv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xv_q    <= (state_d == HOLD);
            err_q   <= err_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < IN; g++) begin : g_lane
            assign we_lane[g] = wr & (cnt_q == CW'(g));
            fc_vec_entry #(.WIDTH(WIDTH)) u_ent (
                .clk (clk),
                .rst (rst),
                .clr (clr),
                .we  (we_lane[g]),
                .d   (s_data),
                .q   (x[g])
            );
        end
    endgenerate
endmodule
